wr_dqs_amble_gen: RTL and testbench
===================================

# wr_dqs_amble_gen

Parametrised DQS strobe generator for the DDR5 PHY write path. It replaces the fixed 8-bit preamble/interamble shifter with a lookahead delay line, and handles these cases:
- programmable preamble length;
- programmable postamble length;
- truncated interamble for any gap length.

It sits between the write manager FSM (which supplies `i_wr_en`) and the DQS serializer (which consumes 2 UI per clock).

## Interface
Parameters:
- `MAX_PRE_CK`, default 4: maximum preamble length in tCK.
- `MAX_PST_CK`, default 2: maximum postamble length in tCK.
- `GAP_W`, default 4: width of the gap counter and `o_gap`.
- `DLY`, default `MAX_PRE_CK+MAX_PST_CK`: pipeline delay from `i_wr_en` to `o_data_valid`. Must be at least `MAX_PRE_CK+MAX_PST_CK`.

Ports:
- `i_clk`, input, 1: clock. One clock equals one tCK.
- `i_rst`, input, 1: reset, asynchronous, active-low.
- `i_wr_en`, input, 1: write data enable, one bit per data tCK. A burst is a contiguous run of 1s.
- `i_pre_len`, input, 3: preamble length in tCK. Valid range is 1..`MAX_PRE_CK`. The values 0 and anything above `MAX_PRE_CK` are treated as `MAX_PRE_CK`.
- `i_pre_pattern`, input, `2*MAX_PRE_CK`: preamble bits, MSB first. Only bits `[2L-1:0]` are used.
- `i_pst_len`, input, 2: postamble length in tCK. The value 0 and anything above `MAX_PST_CK` are treated as `MAX_PST_CK`.
- `o_dqs`, output, 2: DQS bits for this tCK, ordered {rise, fall}.
- `o_dqs_oe`, output, 1: DQS output enable.
- `o_data_valid`, output, 1: asserted in data tCKs. This is `i_wr_en` delayed by `DLY`.
- `o_gap`, output, `GAP_W`: last measured inter-burst gap in tCK.
- `o_state`, output, 3: current FSM state.

## Operation
Delay line:
- `en_d[0..DLY]` is a shift register of `i_wr_en`.
- Output decisions are made for cycle `en_d[DLY]`, using `en_d[DLY-1:0]` as lookahead.

Configuration latch:
- `L` and `P` are latched from `i_pre_len` / `i_pst_len`, together with the pattern, only while in `IDLE` with an all-zero delay line.
- They are held constant otherwise.

Per output tCK, evaluated in priority order:
1. Data cycle (`en_d[DLY]`=1): `o_dqs`=2'b10, `oe`=1, `o_data_valid`=1.
2. Preamble: the next data start is `d` cycles ahead, with 1≤d≤L. Then `o_dqs` = `pattern[2d-1 -: 2]` and `oe`=1. When the gap is shorter than L, this naturally yields the truncated preamble tail.
3. Postamble: within P cycles after the last data cycle. `o_dqs`=2'b00, `oe`=1.
4. Otherwise idle: `o_dqs`=2'b00, `oe`=0.

FSM states, all registered with `o_state`:
- `IDLE`=0
- `PRE`=1
- `DATA`=2
- `PST`=3
- `INTER`=4: the preamble overlaps the postamble window, i.e. gap < L+P.

Transitions:
- `IDLE`→`PRE` → `DATA` → `PST` → `IDLE`.
- `DATA`→`INTER` when gap < L+P.
- `DATA`→`DATA` when gap = 0 (back-to-back bursts); no strobe break.
- `INTER`→`DATA`.
- `PST`→`PRE` when the next preamble starts exactly after the postamble.

Gap counter:
- Counts non-data cycles after a burst ends.
- Saturates at `2^GAP_W-1`.
- Loaded into `o_gap` on the first data cycle of the next burst.
- Cleared when entering `IDLE`.

Reset (asynchronous, any time, including mid-burst):
- Delay line cleared.
- Outputs go to: `o_dqs`=0, `o_dqs_oe`=0, `o_data_valid`=0, `o_gap`=0, `o_state`=`IDLE`.
- No partial postamble is emitted.

## Timing
- All outputs are registered.
- `i_wr_en` first sampled high at edge t produces `o_data_valid`=1 at output cycle t+`DLY`.
- The preamble occupies cycles t+`DLY`-L .. t+`DLY`-1.
- The postamble occupies the P cycles after the last data cycle, unless it is pre-empted by a preamble.
- `i_wr_en` pulses shorter than 1 tCK are not possible; single-cycle bursts are legal.
- `i_pre_len` / `i_pst_len` changes during activity take effect after the next return to `IDLE`.

## Configuration
Macro: `DQS_GAP_STATS_EN`.
- Defined: the gap counter and `o_gap` are implemented as described above.
- Undefined: no counter is built and `o_gap` is tied to 0. All other behaviour is identical.

## Structure
Package `dqs_amble_pkg` holds:
- the state enum `dqs_state_e`;
- the `DQS_TOGGLE` (2'b10) and `DQS_LOW` (2'b00) constants;
- the function clamping length fields to valid range.

Sub-module `dqs_lookahead`: the delay line plus a next-start distance encoder. It outputs `d` (0 when no start lies within `MAX_PRE_CK`) and `since_last`, the number of cycles since the last data cycle.

## Test plan
Unless stated otherwise: `MAX_PRE_CK`=4, `MAX_PST_CK`=2, `DLY`=6.
1. L=2, pattern 8'h02, P=1, 4-cycle burst:
   - `o_dqs` = 00, 10 (preamble), 10×4, 00 (postamble).
   - `oe` is high for 7 cycles.
   - `o_data_valid` rises 6 cycles after `i_wr_en`.
2. L=4, pattern 8'hA2, P=2, two bursts with gap 1:
   - The gap cycle outputs 2'b10 (last preamble tCK).
   - `oe` stays 1 throughout.
   - `o_state` passes through `INTER`.
   - `o_gap`=1.
3. Same configuration as test 2, gap 5:
   - Gap outputs 00 (postamble) then A2 preamble pairs 10,10,00,10.
   - `o_gap`=5.
4. Same configuration as test 2, gap 8:
   - 2 postamble cycles, 2 idle cycles (`oe`=0), then 4 preamble cycles.
   - `o_state` returns to `IDLE`.
5. Back-to-back bursts (gap 0):
   - Continuous 2'b10; no postamble.
   - `o_state` stays `DATA`.
6. Reset asserted mid-burst:
   - All outputs go to 0 immediately.
   - After release with `i_wr_en`=0, outputs stay 0 and `o_gap`=0.
   - Repeat with `i_pre_len`=0: treated as L=4.

Source files
------------

// File: rtl/dqs_amble_pkg.sv
// Shared types and helpers for the DQS preamble/postamble generator.
//   dqs_state_e : FSM state encoding reported on o_state
//   DQS_TOGGLE  : strobe bits {rise, fall} for a data tCK
//   DQS_LOW     : strobe bits for postamble / idle
//   clamp_len   : maps out-of-range length fields (0 or > max) to max
package dqs_amble_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StPre   = 3'd1,
        StData  = 3'd2,
        StPst   = 3'd3,
        StInter = 3'd4
    } dqs_state_e;

    localparam logic [1:0] DQS_TOGGLE = 2'b10;
    localparam logic [1:0] DQS_LOW    = 2'b00;

    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned max_len);
        return ((len == 0) || (len > max_len)) ? max_len : len;
    endfunction

endpackage

// File: rtl/dqs_amble_gen_lookahead.sv
// dqs_lookahead: i_wr_en delay line plus lookahead decoders.
//   i_clk, i_rst   : clock, async active-low reset
//   i_wr_en        : write data enable from the write manager
//   o_cur          : en_d[DLY], the tCK being decided now
//   o_look[k-1]    : en_d[DLY-k], k = 1..LOOK (k cycles ahead)
//   o_line_idle    : whole delay line is zero
//   o_d            : distance to next data start (1..MAX_PRE_CK), 0 if none in range
//   o_since_last   : cycles since last data tCK (0 on data, saturates, max after reset)
module dqs_lookahead
    import dqs_amble_pkg::*;
#(
    parameter int unsigned MAX_PRE_CK = 4,
    parameter int unsigned MAX_PST_CK = 2,
    parameter int unsigned DLY        = 6,
    parameter int unsigned LOOK       = 5,
    parameter int unsigned D_W        = $clog2(MAX_PRE_CK + 1),
    parameter int unsigned SL_W       = $clog2(MAX_PST_CK + 2)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_wr_en,
    output logic            o_cur,
    output logic [LOOK-1:0] o_look,
    output logic            o_line_idle,
    output logic [D_W-1:0]  o_d,
    output logic [SL_W-1:0] o_since_last
);

    localparam logic [SL_W-1:0] SL_MAX = '1;

    // en_q[k] holds en_d[k+1]; en_d[0] is the live input
    logic [DLY-1:0]  en_q;
    logic [SL_W-1:0] sl_q;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            en_q <= '0;
            // saturated so no postamble follows a reset
            sl_q <= SL_MAX;
        end else begin
            en_q <= {en_q[DLY-2:0], i_wr_en};
            sl_q <= o_since_last;
        end
    end

    assign o_cur       = en_q[DLY-1];
    assign o_line_idle = ~|en_q;

    for (genvar k = 1; k <= LOOK; k++) begin : g_look
        assign o_look[k-1] = en_q[DLY-1-k];
    end

    // Scan far to near so the nearest start wins
    always_comb begin
        o_d = '0;
        for (int k = MAX_PRE_CK; k >= 1; k--) begin
            if (en_q[DLY-1-k]) o_d = D_W'(k);
        end
    end

    always_comb begin
        if (o_cur) o_since_last = '0;
        else if (sl_q == SL_MAX) o_since_last = SL_MAX;
        else o_since_last = sl_q + 1'b1;
    end

endmodule

// File: rtl/wr_dqs_amble_gen.sv
// wr_dqs_amble_gen: DQS strobe generator for the DDR5 write path.
// Decides each output tCK from a delayed copy of i_wr_en with lookahead,
// producing programmable preamble, postamble and truncated interamble.
//   i_clk, i_rst   : clock (1 tCK), async active-low reset
//   i_wr_en        : data enable, one bit per data tCK
//   i_pre_len      : preamble length (0 or > MAX_PRE_CK -> MAX_PRE_CK)
//   i_pre_pattern  : preamble bits, pair d = pattern[2d-1 -: 2] d tCK before data
//   i_pst_len      : postamble length (0 or > MAX_PST_CK -> MAX_PST_CK)
//   o_dqs          : {rise, fall} strobe bits, o_dqs_oe : strobe output enable
//   o_data_valid   : i_wr_en delayed by DLY
//   o_gap          : last measured inter-burst gap
//   o_state        : dqs_state_e
// Optional feature macro DQS_GAP_STATS_EN: builds the gap counter; when undefined
// o_gap is tied to 0.
module wr_dqs_amble_gen
    import dqs_amble_pkg::*;
#(
    parameter int unsigned MAX_PRE_CK = 4,
    parameter int unsigned MAX_PST_CK = 2,
    parameter int unsigned GAP_W      = 4,
    parameter int unsigned DLY        = MAX_PRE_CK + MAX_PST_CK
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_wr_en,
    input  logic [2:0]              i_pre_len,
    input  logic [2*MAX_PRE_CK-1:0] i_pre_pattern,
    input  logic [1:0]              i_pst_len,
    output logic [1:0]              o_dqs,
    output logic                    o_dqs_oe,
    output logic                    o_data_valid,
    output logic [GAP_W-1:0]        o_gap,
    output logic [2:0]              o_state
);

    localparam int unsigned LOOK = MAX_PRE_CK + MAX_PST_CK - 1;
    localparam int unsigned D_W  = $clog2(MAX_PRE_CK + 1);
    localparam int unsigned SL_W = $clog2(MAX_PST_CK + 2);

    logic                    cur;
    logic [LOOK-1:0]         look;
    logic                    line_idle;
    logic [D_W-1:0]          d;
    logic [SL_W-1:0]         since_last;

    logic [2:0]              pre_len_q;
    logic [1:0]              pst_len_q;
    logic [2*MAX_PRE_CK-1:0] pat_q;

    dqs_state_e              state_q, state_d;
    logic [1:0]              dqs_q, dqs_d;
    logic                    oe_q, oe_d;
    logic                    dv_q;

    logic                    pre_hit, pst_hit, near_start;
    logic [1:0]              pre_bits;

    dqs_lookahead #(
        .MAX_PRE_CK (MAX_PRE_CK),
        .MAX_PST_CK (MAX_PST_CK),
        .DLY        (DLY),
        .LOOK       (LOOK),
        .D_W        (D_W),
        .SL_W       (SL_W)
    ) u_lookahead (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_wr_en      (i_wr_en),
        .o_cur        (cur),
        .o_look       (look),
        .o_line_idle  (line_idle),
        .o_d          (d),
        .o_since_last (since_last)
    );

    always_comb begin
        pre_hit = (d != '0) && (int'(d) <= int'(pre_len_q));
        pst_hit = (since_last != '0) && (int'(since_last) <= int'(pst_len_q));
        // A start within L+P-1 tCK of the burst end means the preamble eats the postamble
        near_start = 1'b0;
        for (int k = 1; k <= int'(LOOK); k++) begin
            if ((k < int'(pre_len_q) + int'(pst_len_q)) && look[k-1]) near_start = 1'b1;
        end
        pre_bits = DQS_LOW;
        for (int k = 1; k <= int'(MAX_PRE_CK); k++) begin
            if (int'(d) == k) pre_bits = pat_q[2*k-1 -: 2];
        end
    end

    always_comb begin
        state_d = state_q;
        dqs_d   = DQS_LOW;
        oe_d    = 1'b0;
        if (cur) begin
            state_d = StData;
            dqs_d   = DQS_TOGGLE;
            oe_d    = 1'b1;
        end else begin
            if (pre_hit) begin
                dqs_d = pre_bits;
                oe_d  = 1'b1;
            end else if (pst_hit) begin
                oe_d  = 1'b1;
            end
            unique case (state_q)
                StData:  state_d = near_start ? StInter : StPst;
                StInter: state_d = StInter;
                StIdle, StPre, StPst: begin
                    if (pre_hit) state_d = StPre;
                    else if (pst_hit) state_d = StPst;
                    else state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= StIdle;
            dqs_q     <= DQS_LOW;
            oe_q      <= 1'b0;
            dv_q      <= 1'b0;
            pre_len_q <= 3'(MAX_PRE_CK);
            pst_len_q <= 2'(MAX_PST_CK);
            pat_q     <= '0;
        end else begin
            state_q <= state_d;
            dqs_q   <= dqs_d;
            oe_q    <= oe_d;
            dv_q    <= cur;
            // Config only moves when nothing is in flight
            if ((state_q == StIdle) && line_idle) begin
                pre_len_q <= 3'(clamp_len(32'(i_pre_len), MAX_PRE_CK));
                pst_len_q <= 2'(clamp_len(32'(i_pst_len), MAX_PST_CK));
                pat_q     <= i_pre_pattern;
            end
        end
    end

    assign o_dqs        = dqs_q;
    assign o_dqs_oe     = oe_q;
    assign o_data_valid = dv_q;
    assign o_state      = state_q;

`ifdef DQS_GAP_STATS_EN
    localparam logic [GAP_W-1:0] GAP_MAX = '1;

    logic [GAP_W-1:0] gap_cnt_q, gap_q;
    logic             after_burst_q;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            gap_cnt_q     <= '0;
            gap_q         <= '0;
            after_burst_q <= 1'b0;
        end else if (cur) begin
            if (state_q != StData) gap_q <= gap_cnt_q;
            gap_cnt_q     <= '0;
            after_burst_q <= 1'b1;
        end else if (state_d == StIdle) begin
            gap_cnt_q     <= '0;
            after_burst_q <= 1'b0;
        end else if (after_burst_q && (gap_cnt_q != GAP_MAX)) begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
        end
    end

    assign o_gap = gap_q;
`else
    assign o_gap = '0;
`endif

endmodule

// File: tb/tb_wr_dqs_amble_gen.sv
// Randomized + directed bench for wr_dqs_amble_gen against a history-based model.
module tb_wr_dqs_amble_gen;

    localparam int MAX_PRE_CK = 4;
    localparam int MAX_PST_CK = 2;
    localparam int GAP_W      = 4;
    localparam int DLY        = 6;
    localparam int HIST       = 8192;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic       i_wr_en = 1'b0;
    logic [2:0] i_pre_len = 3'd2;
    logic [7:0] i_pre_pattern = 8'h02;
    logic [1:0] i_pst_len = 2'd1;
    logic [1:0] o_dqs;
    logic       o_dqs_oe;
    logic       o_data_valid;
    logic [GAP_W-1:0] o_gap;
    logic [2:0] o_state;

    wr_dqs_amble_gen #(
        .MAX_PRE_CK (MAX_PRE_CK),
        .MAX_PST_CK (MAX_PST_CK),
        .GAP_W      (GAP_W),
        .DLY        (DLY)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_wr_en       (i_wr_en),
        .i_pre_len     (i_pre_len),
        .i_pre_pattern (i_pre_pattern),
        .i_pst_len     (i_pst_len),
        .o_dqs         (o_dqs),
        .o_dqs_oe      (o_dqs_oe),
        .o_data_valid  (o_data_valid),
        .o_gap         (o_gap),
        .o_state       (o_state)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    bit   w_hist [HIST];
    int   cyc;
    int   mod_l, mod_p;
    logic [7:0] mod_pat;
    int   exp_gap;

    int   oe_cnt;
    int   dv_first, wr_first;
    bit   saw_inter;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int clamp(input int v, input int mx);
        return (v == 0 || v > mx) ? mx : v;
    endfunction

    function automatic bit hist(input int i);
        if (i < 0 || i >= HIST) return 1'b0;
        return w_hist[i];
    endfunction

    task automatic model_reset(input int pre, input int pst, input logic [7:0] pat);
        for (int i = 0; i < HIST; i++) w_hist[i] = 1'b0;
        cyc     = 0;
        exp_gap = 0;
        mod_l   = clamp(pre, MAX_PRE_CK);
        mod_p   = clamp(pst, MAX_PST_CK);
        mod_pat = pat;
    endtask

    // One tCK: drive on negedge, record at posedge, compare 1 time unit later
    task automatic step(input logic en);
        int   n, s, nx, g;
        bit   cur, pre, pst;
        logic [1:0] e_dqs;
        logic e_oe;
        logic [2:0] e_st;
        logic [31:0] e_gap;
        @(negedge i_clk);
        i_wr_en = en;
        @(posedge i_clk);
        n = cyc;
        if (cyc < HIST) w_hist[cyc] = en;
        cyc++;
        #1;
        cur = hist(n - DLY);
        s = 0;
        for (int k = 1; k <= 64; k++) begin
            if (hist(n - DLY - k)) begin s = k; break; end
        end
        nx = 0;
        for (int k = 1; k <= DLY; k++) begin
            if (hist(n - DLY + k)) begin nx = k; break; end
        end
        if (cur) begin
            e_dqs = 2'b10; e_oe = 1'b1; e_st = 3'd2;
            if (!hist(n - DLY - 1)) begin
                g = s - 1;
                exp_gap = (s >= 1 && g <= mod_l + mod_p) ? ((g > 15) ? 15 : g) : 0;
            end
        end else begin
            pre   = (nx >= 1 && nx <= mod_l);
            pst   = (s >= 1 && s <= mod_p);
            e_dqs = pre ? 2'((mod_pat >> (2 * (nx - 1))) & 8'h03) : 2'b00;
            e_oe  = pre || pst;
            if (s >= 1 && nx >= 1 && (s + nx - 1) < mod_l + mod_p) e_st = 3'd4;
            else if (pre) e_st = 3'd1;
            else if (pst) e_st = 3'd3;
            else e_st = 3'd0;
        end
`ifdef DQS_GAP_STATS_EN
        e_gap = 32'(exp_gap);
`else
        e_gap = 32'd0;
`endif
        check_eq($sformatf("dqs@%0d", n), 32'(o_dqs), 32'(e_dqs));
        check_eq($sformatf("oe@%0d", n), 32'(o_dqs_oe), 32'(e_oe));
        check_eq($sformatf("dv@%0d", n), 32'(o_data_valid), 32'(cur));
        check_eq($sformatf("state@%0d", n), 32'(o_state), 32'(e_st));
        check_eq($sformatf("gap@%0d", n), 32'(o_gap), e_gap);
        if (o_dqs_oe) oe_cnt++;
        if (o_data_valid && dv_first < 0) dv_first = n;
        if (o_state == 3'd4) saw_inter = 1'b1;
    endtask

    task automatic run(input logic en, input int n);
        repeat (n) step(en);
    endtask

    task automatic set_cfg(input int pre, input int pst, input logic [7:0] pat);
        run(1'b0, 12);
        i_pre_len     = 3'(pre);
        i_pst_len     = 2'(pst);
        i_pre_pattern = pat;
        mod_l   = clamp(pre, MAX_PRE_CK);
        mod_p   = clamp(pst, MAX_PST_CK);
        mod_pat = pat;
        run(1'b0, 2);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_dqs"}, 32'(o_dqs), 32'd0);
        check_eq({tag, "_oe"}, 32'(o_dqs_oe), 32'd0);
        check_eq({tag, "_dv"}, 32'(o_data_valid), 32'd0);
        check_eq({tag, "_gap"}, 32'(o_gap), 32'd0);
        check_eq({tag, "_state"}, 32'(o_state), 32'd0);
    endtask

    initial begin
        // Test 1: L=2, pattern 02, P=1, 4-cycle burst
        model_reset(2, 1, 8'h02);
        repeat (3) @(posedge i_clk);
        #2;
        check_all_zero("reset");
        i_rst = 1'b1;
        run(1'b0, 4);
        oe_cnt = 0; dv_first = -1; wr_first = cyc;
        run(1'b1, 4);
        run(1'b0, 12);
        check_eq("t1_oe_cycles", 32'(oe_cnt), 32'd7);
        check_eq("t1_dv_latency", 32'(dv_first - wr_first), 32'(DLY));

        // Test 2: L=4, A2, P=2, gap 1
        set_cfg(4, 2, 8'hA2);
        saw_inter = 1'b0;
        run(1'b1, 3); run(1'b0, 1); run(1'b1, 3);
        run(1'b0, 12);
        check_eq("t2_inter_seen", 32'(saw_inter), 32'd1);
`ifdef DQS_GAP_STATS_EN
        check_eq("t2_gap", 32'(o_gap), 32'd1);
`endif
        // Test 3: gap 5; Test 4: gap 8; Test 5: back-to-back
        run(1'b1, 3); run(1'b0, 5); run(1'b1, 3); run(1'b0, 12);
        run(1'b1, 3); run(1'b0, 8); run(1'b1, 3); run(1'b0, 12);
        run(1'b1, 3); run(1'b1, 3); run(1'b0, 12);

        // Test 6: reset mid-burst with a measured gap pending
        run(1'b1, 3); run(1'b0, 2); run(1'b1, 8);
        #2;
        i_rst = 1'b0;
        #1;
        check_all_zero("midrst");
        i_wr_en   = 1'b0;
        i_pre_len = 3'd0;
        repeat (3) @(posedge i_clk);
        #2;
        i_rst = 1'b1;
        model_reset(0, 2, 8'hA2);
        run(1'b0, 10);
        check_all_zero("postrst");
        run(1'b1, 2); run(1'b0, 3); run(1'b1, 2); run(1'b0, 12);

        // Randomized bursts, gaps and configuration
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 5) == 0)
                set_cfg(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                        8'($urandom_range(0, 255)));
            run(1'b1, int'($urandom_range(1, 6)));
            run(1'b0, int'($urandom_range(0, 9)));
        end
        run(1'b0, 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
